muldiv_seq: RTL and testbench

Iterative 32x32 multiply/divide sequencer for the EX stage. It owns the HI/LO registers and runs MULT/MULTU/DIV/DIVU as a 32-step loop. Each step drives the shared 32-bit ALU through its `A`/`B`/`ALU_operation` inputs and consumes its `res` output. The parent stage instantiates the ALU, muxes its inputs to this block while `busy`, and stalls the pipeline on `busy`.

---
 rtl/muldiv_seq_pkg.sv | 28 ++
 rtl/muldiv_seq.sv | 134 +++++++++++++
 tb/tb_muldiv_seq.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/muldiv_seq_pkg.sv
// muldiv_seq_pkg: shared ALU operation codes plus the multiply/divide op and sequencer state encodings.
package muldiv_seq_pkg;

   localparam logic [3:0] ALUC_AND = 4'b0000;
   localparam logic [3:0] ALUC_OR  = 4'b0001;
   localparam logic [3:0] ALUC_ADD = 4'b0010;
   localparam logic [3:0] ALUC_XOR = 4'b0011;
   localparam logic [3:0] ALUC_NOR = 4'b0100;
   localparam logic [3:0] ALUC_SLL = 4'b0101;
   localparam logic [3:0] ALUC_SUB = 4'b0110;
   localparam logic [3:0] ALUC_SLT = 4'b0111;
   localparam logic [3:0] ALUC_SRL = 4'b1000;
   localparam logic [3:0] ALUC_SRA = 4'b1001;
   localparam logic [3:0] ALUC_LUI = 4'b1010;

   localparam logic [1:0] MD_MULTU = 2'b00;
   localparam logic [1:0] MD_DIVU  = 2'b01;
   localparam logic [1:0] MD_MULT  = 2'b10;
   localparam logic [1:0] MD_DIV   = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_FIX  = 2'b10,
      S_DONE = 2'b11
   } md_state_t;

endpackage

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative 32x32 MULT/DIV sequencer that owns HI/LO and steps the shared EX-stage ALU.
// Signed MULT/DIV and the FIX state are compiled in with `define MULDIV_SIGNED_EN.
module muldiv_seq
   import muldiv_seq_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [3:0]       alu_op,
   input  logic [WIDTH-1:0] alu_res,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int CW = $clog2(WIDTH);

   md_state_t        state, state_n;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] md, hi_n, lo_n, a_mag, b_mag, s;
   logic             is_div, is_div_in, a_neg, b_neg, q, c, last;

   assign busy      = state != S_IDLE;
   assign done      = state == S_DONE;
   assign last      = cnt == CW'(WIDTH - 1);
   assign is_div_in = (op == MD_DIVU) || (op == MD_DIV);
   // Restoring-divide view: shifted remainder with the bit shifted out of hi kept as q's override.
   assign s         = {hi[WIDTH-2:0], lo[WIDTH-1]};
   assign q         = hi[WIDTH-1] | (s >= md);
   assign c         = alu_res < hi;

`ifdef MULDIV_SIGNED_EN
   logic neg_q, neg_r;
   assign a_neg = (op == MD_MULT || op == MD_DIV) & a_in[WIDTH-1];
   assign b_neg = (op == MD_MULT || op == MD_DIV) & b_in[WIDTH-1];
`else
   assign a_neg = 1'b0;
   assign b_neg = 1'b0;
`endif
   assign a_mag = a_neg ? -a_in : a_in;
   assign b_mag = b_neg ? -b_in : b_in;

   always_comb begin
      state_n = state;
      alu_a   = '0;
      alu_b   = '0;
      alu_op  = ALUC_ADD;
      case (state)
         S_IDLE: state_n = start ? S_RUN : S_IDLE;
         S_RUN: begin
            alu_a  = is_div ? s : hi;
            alu_b  = (is_div || lo[0]) ? md : '0;
            alu_op = is_div ? ALUC_SUB : ALUC_ADD;
`ifdef MULDIV_SIGNED_EN
            state_n = last ? S_FIX : S_RUN;
`else
            state_n = last ? S_DONE : S_RUN;
`endif
         end
`ifdef MULDIV_SIGNED_EN
         S_FIX:  state_n = S_DONE;
`endif
         default: state_n = S_IDLE;
      endcase
   end

   always_comb begin
      hi_n = hi;
      lo_n = lo;
      case (state)
         S_IDLE: begin
            hi_n = start ? '0 : (hi_we ? wdata : hi);
            lo_n = start ? a_mag : (lo_we ? wdata : lo);
         end
         S_RUN: begin
            hi_n = is_div ? (q ? alu_res : s) : {c, alu_res[WIDTH-1:1]};
            lo_n = is_div ? {lo[WIDTH-2:0], q} : {alu_res[0], lo[WIDTH-1:1]};
         end
`ifdef MULDIV_SIGNED_EN
         // Remainder follows the dividend's sign; quotient/product follow the sign product.
         S_FIX: begin
            if (is_div) begin
               hi_n = neg_r ? -hi : hi;
               lo_n = neg_q ? -lo : lo;
            end else if (neg_q) begin
               {hi_n, lo_n} = -{hi, lo};
            end
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         cnt    <= '0;
         md     <= '0;
         is_div <= 1'b0;
         hi     <= '0;
         lo     <= '0;
`ifdef MULDIV_SIGNED_EN
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
`endif
      end else begin
         state <= state_n;
         hi    <= hi_n;
         lo    <= lo_n;
         if (state == S_IDLE && start) begin
            md     <= b_mag;
            is_div <= is_div_in;
            cnt    <= '0;
`ifdef MULDIV_SIGNED_EN
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
`endif
         end else if (state == S_RUN) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: table-driven and scoreboarded bench for muldiv_seq with a behavioural shared ALU.
// Honours `define MULDIV_SIGNED_EN for signed expectations and the extra FIX cycle.
module tb_muldiv_seq;
   import muldiv_seq_pkg::*;

`ifdef MULDIV_SIGNED_EN
   localparam int LAT = 34;
`else
   localparam int LAT = 33;
`endif

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a, b, hi, lo;
   } vec_t;

   logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] a_in = '0, b_in = '0, wdata = '0;
   logic [31:0] alu_a, alu_b, alu_res, hi, lo;
   logic [3:0]  alu_op;
   logic        busy, done;
   int          total = 0, bad = 0;
   logic [63:0] sb[$];
   logic [63:0] exp_q;
   vec_t        vecs[$];

   always #5 clk = ~clk;

   assign alu_res = (alu_op == ALUC_SUB) ? alu_a - alu_b : alu_a + alu_b;

   muldiv_seq #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
      .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .alu_a(alu_a), .alu_b(alu_b),
      .alu_op(alu_op), .alu_res(alu_res), .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic add(input logic [1:0] o, input logic [31:0] a, b, eh, el);
      vec_t v;
      v = '{op: o, a: a, b: b, hi: eh, lo: el};
      vecs.push_back(v);
   endtask

   // Scoreboard: every done pulse retires the oldest expected {hi,lo}.
   always @(negedge clk) begin
      if (done) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL done_unexpected: got done=1 expected no pending result");
         end else begin
            exp_q = sb.pop_front();
            total--;
            chk("result_hi_lo", {hi, lo}, exp_q);
         end
      end
   end

   task automatic do_op(input logic [1:0] o, input logic [31:0] a, b, eh, el,
                        input bit wr, input bit mid);
      int n;
      @(negedge clk);
      op = o; a_in = a; b_in = b; start = 1'b1; hi_we = wr; wdata = 32'hAA;
      sb.push_back({eh, el});
      n = 0;
      do begin
         @(negedge clk);
         n++;
         start = 1'b0;
         hi_we = 1'b0;
         chk("busy_in_op", {63'd0, busy}, 64'd1);
         if (n == 1) chk("alu_op_run", {60'd0, alu_op}, {60'd0, o[0] ? ALUC_SUB : ALUC_ADD});
         if (mid && n == 5) begin
            start = 1'b1; hi_we = 1'b1; op = MD_MULTU; a_in = 32'd5; b_in = 32'd5;
         end
      end while (!done && n < 100);
      chk("done_latency", 64'(n), 64'(LAT));
      @(negedge clk);
      chk("busy_after_done", {63'd0, busy}, 64'd0);
      chk("done_one_cycle", {63'd0, done}, 64'd0);
      chk("hold_hi_lo", {hi, lo}, {eh, el});
   endtask

   initial begin
      add(MD_MULTU, 32'd7,        32'd6,        32'd0,        32'd42);
      add(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
      add(MD_MULTU, 32'h80000000, 32'd2,        32'd1,        32'd0);
      add(MD_DIVU,  32'd100,      32'd7,        32'd2,        32'd14);
      add(MD_DIVU,  32'h1234,     32'd0,        32'h1234,     32'hFFFFFFFF);
      add(MD_DIVU,  32'd5,        32'd9,        32'd5,        32'd0);
`ifdef MULDIV_SIGNED_EN
      add(MD_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1);
      add(MD_MULT,  32'hFFFFFFFC, 32'hFFFFFFFC, 32'd0,        32'd16);
      add(MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
      add(MD_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD);
`else
      add(MD_MULT,  32'hFFFFFFFD, 32'd5,        32'd4,        32'hFFFFFFF1);
      add(MD_MULT,  32'hFFFFFFFC, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'd16);
      add(MD_DIV,   32'hFFFFFFF9, 32'd2,        32'd1,        32'h7FFFFFFC);
      add(MD_DIV,   32'd7,        32'hFFFFFFFE, 32'd7,        32'd0);
`endif

      #1;
      chk("rst_busy",   {63'd0, busy},   64'd0);
      chk("rst_done",   {63'd0, done},   64'd0);
      chk("rst_hi_lo",  {hi, lo},        64'd0);
      chk("rst_alu_ab", {alu_a, alu_b},  64'd0);
      chk("rst_alu_op", {60'd0, alu_op}, {60'd0, ALUC_ADD});
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, 1'b0, 1'b0);

      // MTHI / MTLO in IDLE, singly and together.
      @(negedge clk); hi_we = 1'b1; wdata = 32'h11112222;
      @(negedge clk); hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h33334444;
      chk("mthi", {32'd0, hi}, 64'h11112222);
      @(negedge clk); lo_we = 1'b0;
      chk("mtlo", {hi, lo}, 64'h11112222_33334444);
      @(negedge clk); hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h5A5A5A5A;
      @(negedge clk); hi_we = 1'b0; lo_we = 1'b0;
      chk("mthi_mtlo", {hi, lo}, 64'h5A5A5A5A_5A5A5A5A);

      // start beats a same-cycle write; writes and starts during RUN are ignored.
      do_op(MD_MULTU, 32'd7, 32'd6, 32'd0, 32'd42, 1'b1, 1'b0);
      do_op(MD_MULTU, 32'd100, 32'd3, 32'd0, 32'd300, 1'b0, 1'b1);
      do_op(MD_DIVU, 32'd1000, 32'd7, 32'd6, 32'd142, 1'b0, 1'b1);

      // Reset in cycle 10 of a divide aborts without a done pulse.
      @(negedge clk);
      op = MD_DIVU; a_in = 32'd1000; b_in = 32'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      chk("pre_abort_alu_op", {60'd0, alu_op}, {60'd0, ALUC_SUB});
      rst_n = 1'b0;
      #1;
      chk("abort_busy",   {63'd0, busy},   64'd0);
      chk("abort_done",   {63'd0, done},   64'd0);
      chk("abort_hi_lo",  {hi, lo},        64'd0);
      chk("abort_alu_ab", {alu_a, alu_b},  64'd0);
      chk("abort_alu_op", {60'd0, alu_op}, {60'd0, ALUC_ADD});
      @(negedge clk);
      rst_n = 1'b1;
      do_op(MD_MULTU, 32'd123, 32'd456, 32'd0, 32'd56088, 1'b0, 1'b0);

      // Random unsigned operands against a 64-bit arithmetic model.
      for (int k = 0; k < 6; k++) begin
         logic [31:0] a, b;
         logic [63:0] p;
         a = $urandom;
         b = (k % 2 == 0) ? $urandom : $urandom_range(1, 1000);
         p = {32'd0, a} * {32'd0, b};
         do_op(MD_MULTU, a, b, p[63:32], p[31:0], 1'b0, 1'b0);
         do_op(MD_DIVU, a, b, a % b, a / b, 1'b0, 1'b0);
      end

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
